// File: rtl/column_writer.sv
// column_writer: renders one screen column into a line RAM.
// A serial divider derives TEX_H/height, then rows are filled one per cycle
// with ceiling colour, texture texels (incremental texture-row tracking) or
// floor colour. The line RAM is read back through a registered port.
// Optional double buffering of the line RAM: define COLUMN_WRITER_DBUF_EN.
module column_writer #(
    parameter int SCREEN_H = 240,
    parameter int TEX_W    = 128,
    parameter int TEX_H    = 64,
    parameter int PIX_W    = 8,
    parameter int HEIGHT_W = 16
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic [15:0]                            pixel,
    input  logic [HEIGHT_W-1:0]                    height,
    input  logic [$clog2(TEX_W)-1:0]               tex_x,
    input  logic [PIX_W-1:0]                       ceil_color,
    input  logic [PIX_W-1:0]                       floor_color,
    output logic                                   rdy,
    output logic                                   done,
    output logic [15:0]                            col_out,
    output logic [$clog2(TEX_H)+$clog2(TEX_W)-1:0] tex_addr,
    input  logic [PIX_W-1:0]                       tex_data,
    input  logic                                   swap,
    input  logic [$clog2(SCREEN_H)-1:0]            ram_raddr,
    output logic [PIX_W-1:0]                       ram_read_data
);
    localparam int TX_W = $clog2(TEX_W);
    localparam int TY_W = $clog2(TEX_H);
    localparam int RA_W = $clog2(SCREEN_H);
`ifdef COLUMN_WRITER_DBUF_EN
    localparam int NBANK = 2;
`else
    localparam int NBANK = 1;
`endif
    localparam logic [HEIGHT_W:0] LP_SH  = (HEIGHT_W+1)'(SCREEN_H);
    localparam logic [RA_W:0]     LP_SHA = (RA_W+1)'(SCREEN_H);

    typedef enum logic [2:0] {S_IDLE, S_DIV, S_SKIP, S_FILL, S_DRAIN} state_t;

    state_t r_state, w_next;

    logic [HEIGHT_W-1:0] r_cnt;
    logic [15:0]         r_pixel;
    logic [HEIGHT_W-1:0] r_height;
    logic [TX_W-1:0]     r_tex_x;
    logic [PIX_W-1:0]    r_ceil, r_floor;
    logic [HEIGHT_W-1:0] r_quo, r_rem;
    logic [HEIGHT_W-1:0] r_ty, r_frac;
    logic                r_done;
    logic                r_wr_en, r_wr_wall;
    logic [RA_W-1:0]     r_wr_addr;
    logic [PIX_W-1:0]    r_wr_color;
    logic [PIX_W-1:0]    r_rd_data;
    logic [PIX_W-1:0]    r_mem [NBANK][SCREEN_H];

    logic [HEIGHT_W:0]   w_h_ext, w_diff, w_half, w_top, w_k, w_wall_end, w_y;
    logic                w_big, w_wall, w_above;
    logic [HEIGHT_W:0]   w_trial, w_trial_sub, w_sum, w_sum_sub;
    logic                w_front, w_back;
    logic                w_unused;

    // Wall placement derived from the latched height
    always_comb begin
        w_h_ext    = {1'b0, r_height};
        w_big      = w_h_ext > LP_SH;
        w_diff     = w_big ? (w_h_ext - LP_SH) : (LP_SH - w_h_ext);
        w_half     = w_diff >> 1;
        w_top      = w_big ? '0 : w_half;
        w_k        = w_big ? w_half : '0;
        w_wall_end = w_top + w_h_ext;
        w_y        = {1'b0, r_cnt};
        w_wall     = w_big || ((w_y >= w_top) && (w_y < w_wall_end));
        w_above    = !w_big && (w_y < w_top);
    end

    // Restoring-divider trial subtraction and texture-row accumulator sum
    always_comb begin
        w_trial     = {r_rem, r_quo[HEIGHT_W-1]};
        w_trial_sub = w_trial - w_h_ext;
        w_sum       = {1'b0, r_frac} + {1'b0, r_rem};
        w_sum_sub   = w_sum - w_h_ext;
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    // FSM next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_DIV;
            S_DIV:   if (r_cnt == HEIGHT_W'(HEIGHT_W-1)) w_next = (w_k != '0) ? S_SKIP : S_FILL;
            S_SKIP:  if (w_y == w_k - 1'b1) w_next = S_FILL;
            S_FILL:  if (w_y == LP_SH - 1'b1) w_next = S_DRAIN;
            S_DRAIN: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // FSM outputs: ready flag and texture ROM address for wall rows
    always_comb begin
        rdy      = (r_state == S_IDLE);
        tex_addr = '0;
        if (r_state == S_FILL && w_wall) tex_addr = {r_ty[TY_W-1:0], r_tex_x};
    end

    // Column parameters, step counter, divider and texture-row tracking
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt    <= '0;
            r_pixel  <= '0;
            r_height <= '0;
            r_tex_x  <= '0;
            r_ceil   <= '0;
            r_floor  <= '0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_ty     <= '0;
            r_frac   <= '0;
        end else begin
            if (r_state == S_IDLE || w_next != r_state) r_cnt <= '0;
            else                                        r_cnt <= r_cnt + 1'b1;
            case (r_state)
                S_IDLE: if (start) begin
                    r_pixel  <= pixel;
                    r_height <= height;
                    r_tex_x  <= tex_x;
                    r_ceil   <= ceil_color;
                    r_floor  <= floor_color;
                    r_quo    <= HEIGHT_W'(TEX_H);
                    r_rem    <= '0;
                    r_ty     <= '0;
                    r_frac   <= '0;
                end
                S_DIV: begin
                    if (w_trial >= w_h_ext) begin
                        r_rem <= w_trial_sub[HEIGHT_W-1:0];
                        r_quo <= {r_quo[HEIGHT_W-2:0], 1'b1};
                    end else begin
                        r_rem <= w_trial[HEIGHT_W-1:0];
                        r_quo <= {r_quo[HEIGHT_W-2:0], 1'b0};
                    end
                end
                S_SKIP, S_FILL: if (r_state == S_SKIP || w_wall) begin
                    // w*TEX_H = ty*h + frac; adding TEX_H = q*h + r needs at most one carry
                    if (w_sum >= w_h_ext) begin
                        r_frac <= w_sum_sub[HEIGHT_W-1:0];
                        r_ty   <= r_ty + r_quo + 1'b1;
                    end else begin
                        r_frac <= w_sum[HEIGHT_W-1:0];
                        r_ty   <= r_ty + r_quo;
                    end
                end
                default: ;
            endcase
        end
    end

    // Write pipeline: row data lands one cycle after its texture issue
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_en    <= 1'b0;
            r_wr_wall  <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_color <= '0;
            r_done     <= 1'b0;
        end else begin
            r_wr_en    <= (r_state == S_FILL);
            r_wr_wall  <= w_wall;
            r_wr_addr  <= r_cnt[RA_W-1:0];
            r_wr_color <= w_above ? r_ceil : r_floor;
            r_done     <= (r_state == S_DRAIN);
        end
    end

`ifdef COLUMN_WRITER_DBUF_EN
    logic r_front, r_swap_pend;

    // Front-bank selection; swaps requested while busy wait for the done edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_front     <= 1'b0;
            r_swap_pend <= 1'b0;
        end else if (r_state == S_IDLE) begin
            if (swap) r_front <= ~r_front;
            r_swap_pend <= 1'b0;
        end else if (r_state == S_DRAIN) begin
            if (swap || r_swap_pend) r_front <= ~r_front;
            r_swap_pend <= 1'b0;
        end else if (swap) begin
            r_swap_pend <= 1'b1;
        end
    end

    assign w_front  = r_front;
    assign w_back   = ~r_front;
    assign w_unused = ^r_ty[HEIGHT_W-1:TY_W];
`else
    assign w_front  = 1'b0;
    assign w_back   = 1'b0;
    assign w_unused = ^{swap, r_ty[HEIGHT_W-1:TY_W]};
`endif

    // Line RAM write port (contents are not reset)
    always_ff @(posedge clk) begin
        if (r_wr_en) r_mem[w_back][r_wr_addr] <= r_wr_wall ? tex_data : r_wr_color;
    end

    // Registered line RAM read port; out-of-range addresses read as zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                             r_rd_data <= '0;
        else if ({1'b0, ram_raddr} >= LP_SHA) r_rd_data <= '0;
        else                                  r_rd_data <= r_mem[w_front][ram_raddr];
    end

    assign done          = r_done;
    assign col_out       = r_pixel;
    assign ram_read_data = r_rd_data;

endmodule

// File: tb/tb_column_writer.sv
// Directed testbench for column_writer (SCREEN_H=240, TEX_H=64, HEIGHT_W=16).
// The texture ROM model returns tex_y as the texel value.
module tb_column_writer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] pixel = '0;
    logic [15:0] height = '0;
    logic [6:0]  tex_x = '0;
    logic [7:0]  ceil_color = '0;
    logic [7:0]  floor_color = '0;
    logic        rdy, done;
    logic [15:0] col_out;
    logic [12:0] tex_addr;
    logic [7:0]  tex_data;
    logic        swap = 1'b0;
    logic [7:0]  ram_raddr = '0;
    logic [7:0]  ram_read_data;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_issue = 0;
    int n_bad   = 0;

    column_writer #(
        .SCREEN_H(240), .TEX_W(128), .TEX_H(64), .PIX_W(8), .HEIGHT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .pixel(pixel), .height(height),
        .tex_x(tex_x), .ceil_color(ceil_color), .floor_color(floor_color),
        .rdy(rdy), .done(done), .col_out(col_out), .tex_addr(tex_addr),
        .tex_data(tex_data), .swap(swap), .ram_raddr(ram_raddr),
        .ram_read_data(ram_read_data)
    );

    always #5 clk = ~clk;

    // Texture ROM: one-cycle latency, texel value equals texture row
    always @(posedge clk) tex_data <= {2'b00, tex_addr[12:7]};

    // Count wall-row issues and those carrying the wrong texture column
    always @(negedge clk) begin
        if (tex_addr != '0) begin
            n_issue++;
            if (tex_addr[6:0] != 7'd15) n_bad++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_row(input string tag, input logic [7:0] a, input logic [7:0] exp);
        @(negedge clk);
        ram_raddr = a;
        @(posedge clk);
        #1;
        check(tag, {24'b0, ram_read_data}, {24'b0, exp});
    endtask

    // Make the freshly written bank visible when double buffering
    task automatic show_new();
`ifdef COLUMN_WRITER_DBUF_EN
        @(negedge clk);
        swap = 1'b1;
        @(posedge clk);
        #1;
        swap = 1'b0;
`endif
    endtask

    // Start a column and wait (bounded) for rdy; optionally poke start+swap mid-run
    task automatic run_column(input logic [15:0] h, input logic [6:0] tx,
                              input logic [7:0] c, input logic [7:0] f,
                              input logic [15:0] pix, input int poke_at,
                              output int cycles, output int ndone);
        @(negedge clk);
        height = h; tex_x = tx; ceil_color = c; floor_color = f; pixel = pix;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cycles = 0;
        ndone  = 0;
        while (cycles < 2000) begin
            @(posedge clk);
            #1;
            cycles++;
            start = 1'b0;
            swap  = 1'b0;
            if (done) ndone++;
            if (rdy) break;
            if (cycles == poke_at) begin
                start = 1'b1;
                pixel = 16'h0099;
                swap  = 1'b1;
            end
        end
    endtask

    initial begin
        int cyc, nd, issue0, bad0, nd_rst;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_rdy", {31'b0, rdy}, 32'd1);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_col_out", {16'b0, col_out}, 32'd0);
        check("rst_tex_addr", {19'b0, tex_addr}, 32'd0);
        check("rst_rd_data", {24'b0, ram_read_data}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // h=0: all ceiling then all floor
        run_column(16'd0, 7'd3, 8'h11, 8'h22, 16'h0005, -1, cyc, nd);
        check("h0_cycles", cyc, 32'd257);
        check("h0_done", {31'b0, done}, 32'd1);
        check("h0_col_out", {16'b0, col_out}, 32'h0005);
        check("h0_ndone", nd, 32'd1);
        @(posedge clk);
        #1;
        check("h0_done_pulse", {31'b0, done}, 32'd0);
        show_new();
        check_row("h0_row0", 8'd0, 8'h11);
        check_row("h0_row119", 8'd119, 8'h11);
        check_row("h0_row120", 8'd120, 8'h22);
        check_row("h0_row239", 8'd239, 8'h22);

        // h=120, tex_x=15: centred wall
        issue0 = n_issue;
        bad0   = n_bad;
        run_column(16'd120, 7'd15, 8'hAA, 8'hBB, 16'h0123, -1, cyc, nd);
        check("h120_cycles", cyc, 32'd257);
        check("h120_col_out", {16'b0, col_out}, 32'h0123);
        check("h120_issues", n_issue - issue0, 32'd120);
        check("h120_bad_tex_x", n_bad - bad0, 32'd0);
        show_new();
        check_row("h120_row0", 8'd0, 8'hAA);
        check_row("h120_row59", 8'd59, 8'hAA);
        check_row("h120_row60", 8'd60, 8'd0);
        check_row("h120_row61", 8'd61, 8'd0);
        check_row("h120_row62", 8'd62, 8'd1);
        check_row("h120_row179", 8'd179, 8'd63);
        check_row("h120_row180", 8'd180, 8'hBB);
        check_row("h120_row239", 8'd239, 8'hBB);

        // h=480: wall covers the screen, k=120 rows skipped
        run_column(16'd480, 7'd9, 8'hCC, 8'hDD, 16'h0456, -1, cyc, nd);
        check("h480_cycles", cyc, 32'd377);
        check("h480_ndone", nd, 32'd1);
        show_new();
        check_row("h480_row0", 8'd0, 8'd16);
        check_row("h480_row120", 8'd120, 8'd32);
        check_row("h480_row239", 8'd239, 8'd47);

        // Out-of-range read address
        check_row("raddr240", 8'd240, 8'd0);
        check_row("raddr255", 8'd255, 8'd0);

        // Second start (with swap) mid-FILL: ignored, single done
        @(negedge clk);
        ram_raddr = 8'd0;
        run_column(16'd0, 7'd1, 8'h77, 8'h88, 16'h0042, 100, cyc, nd);
        check("busy_cycles", cyc, 32'd257);
        check("busy_ndone", nd, 32'd1);
        check("busy_col_out", {16'b0, col_out}, 32'h0042);
`ifdef COLUMN_WRITER_DBUF_EN
        check("swap_not_before", {24'b0, ram_read_data}, 32'd16);
`else
        check("swap_not_before", {24'b0, ram_read_data}, 32'h77);
`endif
        @(posedge clk);
        #1;
        check("swap_on_done", {24'b0, ram_read_data}, 32'h77);
        check("busy_done_pulse", {31'b0, done}, 32'd0);

        // Reset mid-FILL abandons the column
        @(negedge clk);
        height = 16'd0; ceil_color = 8'h33; floor_color = 8'h44; pixel = 16'h0777;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (100) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_rdy", {31'b0, rdy}, 32'd1);
        check("midrst_done", {31'b0, done}, 32'd0);
        check("midrst_tex_addr", {19'b0, tex_addr}, 32'd0);
        check("midrst_col_out", {16'b0, col_out}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        nd_rst = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (done) nd_rst++;
        end
        check("midrst_no_done", nd_rst, 32'd0);
        check("midrst_rdy_after", {31'b0, rdy}, 32'd1);

        run_column(16'd0, 7'd2, 8'h55, 8'h66, 16'h0BEE, -1, cyc, nd);
        check("post_rst_cycles", cyc, 32'd257);
        check("post_rst_ndone", nd, 32'd1);
        check("post_rst_col_out", {16'b0, col_out}, 32'h0BEE);
        show_new();
        check_row("post_rst_row0", 8'd0, 8'h55);
        check_row("post_rst_row239", 8'd239, 8'h66);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
